uart_boot_loader: RTL

- Sequences the single-cycle core at boot: holds the core in reset, receives a program image byte-stream from the UART receiver, and writes it word-by-word into instruction memory.
- Validates the frame with a checksum, then releases the core.
- Sits between the UART RX peripheral, the instruction-memory write port and the core's reset input.

---
 rtl/uart_boot_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a checksummed UART frame into
// instruction memory word by word, then releases the core.
module uart_boot_loader #(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned MAX_WORDS      = 256,
   parameter logic [7:0]  MAGIC          = 8'hA5,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_rx_valid,
   input  logic [7:0]        i_rx_data,
   input  logic              i_run_req,
   output logic              o_imem_we,
   output logic [ADDR_W-1:0] o_imem_addr,
   output logic [31:0]       o_imem_wdata,
   output logic              o_cpu_reset,
   output logic              o_busy,
   output logic              o_err,
   output logic              o_done
);

   typedef enum logic [2:0] {
      StIdle, StLenLo, StLenHi, StData, StCsum, StRun, StErr
   } state_e;

   localparam logic [23:0] TMO_MAX   = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [16:0] MAX_LEN17 = 17'(MAX_WORDS);

   state_e              r_state, w_state_d;
   logic [7:0]          r_len_lo, w_len_lo_d;
   logic [15:0]         r_len, w_len_d;
   logic [7:0]          r_csum, w_csum_d;
   logic [15:0]         r_widx, w_widx_d;
   logic [1:0]          r_bidx, w_bidx_d;
   logic [23:0]         r_asm, w_asm_d;
   logic [23:0]         r_tmo, w_tmo_d;
   logic                r_imem_we, w_imem_we_d;
   logic [ADDR_W-1:0]   r_imem_addr, w_imem_addr_d;
   logic [31:0]         r_imem_wdata, w_imem_wdata_d;
   logic                r_cpu_reset, w_cpu_reset_d;
   logic                r_busy, w_busy_d;
   logic                r_err, w_err_d;
   logic                r_done, w_done_d;

   logic                w_start;
   logic                w_in_frame;
   logic [15:0]         w_len_rx;

   assign w_start    = i_rx_valid && (i_rx_data == MAGIC);
   assign w_in_frame = (r_state == StLenLo) || (r_state == StLenHi) ||
                       (r_state == StData)  || (r_state == StCsum);
   assign w_len_rx   = {i_rx_data, r_len_lo};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_len_lo     <= '0;
         r_len        <= '0;
         r_csum       <= '0;
         r_widx       <= '0;
         r_bidx       <= '0;
         r_asm        <= '0;
         r_tmo        <= '0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_cpu_reset  <= 1'b1;
         r_busy       <= 1'b0;
         r_err        <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_len_lo     <= w_len_lo_d;
         r_len        <= w_len_d;
         r_csum       <= w_csum_d;
         r_widx       <= w_widx_d;
         r_bidx       <= w_bidx_d;
         r_asm        <= w_asm_d;
         r_tmo        <= w_tmo_d;
         r_imem_we    <= w_imem_we_d;
         r_imem_addr  <= w_imem_addr_d;
         r_imem_wdata <= w_imem_wdata_d;
         r_cpu_reset  <= w_cpu_reset_d;
         r_busy       <= w_busy_d;
         r_err        <= w_err_d;
         r_done       <= w_done_d;
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_len_lo_d     = r_len_lo;
      w_len_d        = r_len;
      w_csum_d       = r_csum;
      w_widx_d       = r_widx;
      w_bidx_d       = r_bidx;
      w_asm_d        = r_asm;
      w_tmo_d        = r_tmo;
      w_imem_we_d    = 1'b0;
      w_imem_addr_d  = r_imem_addr;
      w_imem_wdata_d = r_imem_wdata;
      w_cpu_reset_d  = r_cpu_reset;
      w_busy_d       = r_busy;
      w_err_d        = r_err;
      w_done_d       = r_done;

      unique case (r_state)
         StIdle, StRun: begin
            if (w_start) begin
               w_state_d     = StLenLo;
               w_busy_d      = 1'b1;
               w_cpu_reset_d = 1'b1;
               w_err_d       = 1'b0;
               w_done_d      = 1'b0;
               w_csum_d      = '0;
               w_widx_d      = '0;
               w_bidx_d      = '0;
               w_tmo_d       = '0;
            end else if ((r_state == StIdle) && i_run_req) begin
               w_state_d     = StRun;
               w_cpu_reset_d = 1'b0;
            end
         end
         StLenLo: begin
            if (i_rx_valid) begin
               w_len_lo_d = i_rx_data;
               w_csum_d   = r_csum ^ i_rx_data;
               w_state_d  = StLenHi;
            end
         end
         StLenHi: begin
            if (i_rx_valid) begin
               w_len_d  = w_len_rx;
               w_csum_d = r_csum ^ i_rx_data;
               if ({1'b0, w_len_rx} > MAX_LEN17) begin
                  w_state_d = StErr;
                  w_err_d   = 1'b1;
                  w_busy_d  = 1'b0;
               end else if (w_len_rx == 16'd0) begin
                  w_state_d = StCsum;
               end else begin
                  w_state_d = StData;
               end
            end
         end
         StData: begin
            if (i_rx_valid) begin
               w_csum_d = r_csum ^ i_rx_data;
               w_asm_d  = {i_rx_data, r_asm[23:8]};
               w_bidx_d = r_bidx + 2'd1;
               // Write word is latched separately so the assembly register can
               // take the next byte in the same cycle the write goes out.
               if (r_bidx == 2'd3) begin
                  w_imem_we_d    = 1'b1;
                  w_imem_addr_d  = r_widx[ADDR_W-1:0];
                  w_imem_wdata_d = {i_rx_data, r_asm};
                  w_widx_d       = r_widx + 16'd1;
                  if (r_widx == r_len - 16'd1) begin
                     w_state_d = StCsum;
                  end
               end
            end
         end
         StCsum: begin
            if (i_rx_valid) begin
               if (i_rx_data == r_csum) begin
                  w_state_d     = StRun;
                  w_done_d      = 1'b1;
                  w_busy_d      = 1'b0;
                  w_cpu_reset_d = 1'b0;
               end else begin
                  w_state_d = StErr;
                  w_err_d   = 1'b1;
                  w_busy_d  = 1'b0;
               end
            end
         end
         StErr: begin
            w_state_d = StIdle;
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase

      // Inter-byte watchdog; a byte arriving on the expiry cycle takes priority.
      if (w_in_frame) begin
         if (i_rx_valid) begin
            w_tmo_d = '0;
         end else if (r_tmo == TMO_MAX) begin
            w_state_d = StErr;
            w_err_d   = 1'b1;
            w_busy_d  = 1'b0;
            w_tmo_d   = '0;
         end else begin
            w_tmo_d = r_tmo + 24'd1;
         end
      end
   end

   assign o_imem_we    = r_imem_we;
   assign o_imem_addr  = r_imem_addr;
   assign o_imem_wdata = r_imem_wdata;
   assign o_cpu_reset  = r_cpu_reset;
   assign o_busy       = r_busy;
   assign o_err        = r_err;
   assign o_done       = r_done;

endmodule
